// File: rtl/vector_mem_ctrl.sv
// Vector data memory: valid/ready request port, multi-beat array access, registered response.
// Define VMEM_STORE_ACK_EN to make stores produce a response beat (resp_is_store=1).
module vector_mem_ctrl #(
  parameter int ELEM_W     = 32,
  parameter int LANES      = 16,
  parameter int DEPTH      = 512,
  parameter int PORT_LANES = 4,
  localparam int BEATS  = LANES / PORT_LANES,
  localparam int ADDR_W = $clog2(DEPTH / LANES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_is_store,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [LANES-1:0]        req_mask,
  input  logic [LANES*ELEM_W-1:0] req_wdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic                    resp_is_store,
  output logic [LANES*ELEM_W-1:0] resp_data,
  output logic                    busy
);

  // Handshakes: a request transfers on the rising edge where req_valid && req_ready;
  // a response transfers on the rising edge where resp_valid && resp_ready.

  localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int EIDX_W = $clog2(DEPTH);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  state_t                  state;
  logic [BW-1:0]           beat;
  logic                    op_store;
  logic [ADDR_W-1:0]       op_addr;
  logic [LANES-1:0]        op_mask;
  logic [LANES*ELEM_W-1:0] op_wdata;

  logic [ELEM_W-1:0] mem [DEPTH];

  function automatic int lane_of(input logic [BW-1:0] b, input int j);
    return int'(b) * PORT_LANES + j;
  endfunction

  function automatic logic [EIDX_W-1:0] elem_idx(input logic [ADDR_W-1:0] a,
                                                 input logic [BW-1:0] b, input int j);
    return EIDX_W'(int'(a) * LANES + lane_of(b, j));
  endfunction

  // Array is not reset; an async reset forces IDLE, so no beat commits while rst is high.
  always_ff @(posedge clk) begin
    if (state == XFER && op_store) begin
      for (int j = 0; j < PORT_LANES; j++) begin
        if (op_mask[lane_of(beat, j)])
          mem[elem_idx(op_addr, beat, j)] <= op_wdata[ELEM_W*lane_of(beat, j) +: ELEM_W];
      end
    end
  end

`ifdef VMEM_STORE_ACK_EN
  logic resp_is_store_q;
  assign resp_is_store = resp_is_store_q;
`else
  assign resp_is_store = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      beat       <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      busy       <= 1'b0;
      resp_data  <= '0;
      op_store   <= 1'b0;
      op_addr    <= '0;
      op_mask    <= '0;
      op_wdata   <= '0;
`ifdef VMEM_STORE_ACK_EN
      resp_is_store_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            op_store  <= req_is_store;
            op_addr   <= req_addr;
            op_mask   <= req_mask;
            op_wdata  <= req_wdata;
            beat      <= '0;
            state     <= XFER;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (req_is_store) resp_data <= '0;
`ifdef VMEM_STORE_ACK_EN
            resp_is_store_q <= req_is_store;
`endif
          end
        end
        XFER: begin
          if (!op_store) begin
            for (int j = 0; j < PORT_LANES; j++) begin
              resp_data[ELEM_W*lane_of(beat, j) +: ELEM_W] <=
                op_mask[lane_of(beat, j)] ? mem[elem_idx(op_addr, beat, j)] : '0;
            end
          end
          if (beat == LAST_BEAT) begin
            beat <= '0;
`ifdef VMEM_STORE_ACK_EN
            state      <= RESP;
            resp_valid <= 1'b1;
`else
            if (op_store) begin
              state     <= IDLE;
              req_ready <= 1'b1;
              busy      <= 1'b0;
            end else begin
              state      <= RESP;
              resp_valid <= 1'b1;
            end
`endif
          end else begin
            beat <= beat + 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_mem_ctrl.sv
// Scoreboard bench for vector_mem_ctrl: element-array reference model, expected-response
// queue filled at request acceptance, negedge monitor that pops on every response handshake.
module tb_vector_mem_ctrl;

  localparam int ELEM_W     = 32;
  localparam int LANES      = 16;
  localparam int DEPTH      = 512;
  localparam int PORT_LANES = 4;
  localparam int BEATS      = LANES / PORT_LANES;
  localparam int ADDR_W     = $clog2(DEPTH / LANES);
  localparam int NVEC       = DEPTH / LANES;
  localparam int DW         = LANES * ELEM_W;
  localparam int RW         = DW + 1;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_is_store;
  logic [ADDR_W-1:0] req_addr;
  logic [LANES-1:0]  req_mask;
  logic [DW-1:0]     req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_is_store;
  logic [DW-1:0]     resp_data;
  logic              busy;

  vector_mem_ctrl #(
    .ELEM_W(ELEM_W), .LANES(LANES), .DEPTH(DEPTH), .PORT_LANES(PORT_LANES)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_addr(req_addr), .req_mask(req_mask), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_is_store(resp_is_store),
    .resp_data(resp_data), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [RW-1:0]     exp_q[$];
  logic [ELEM_W-1:0] model [DEPTH];
  bit                rand_ready_en = 1'b0;

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] model_load(input int addr, input logic [LANES-1:0] mask);
    logic [DW-1:0] v;
    for (int i = 0; i < LANES; i++)
      v[ELEM_W*i +: ELEM_W] = mask[i] ? model[addr*LANES + i] : '0;
    return v;
  endfunction

  function automatic logic [DW-1:0] rand_vec();
    logic [DW-1:0] v;
    for (int i = 0; i < LANES; i++) v[ELEM_W*i +: ELEM_W] = $urandom;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  // commit_lanes < LANES models a store that is aborted by reset after those lanes landed.
  task automatic issue(input bit st, input int addr, input logic [LANES-1:0] mask,
                       input logic [DW-1:0] wdata, input int commit_lanes);
    int waited = 0;
    @(negedge clk);
    req_is_store = st;
    req_addr     = ADDR_W'(addr);
    req_mask     = mask;
    req_wdata    = wdata;
    req_valid    = 1'b1;
    while (!req_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      n_checks++;
      $display("FAIL req_accept: got req_ready=0 for 100 cycles, required 1");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (st) begin
      for (int i = 0; i < LANES; i++)
        if (mask[i] && i < commit_lanes) model[addr*LANES + i] = wdata[ELEM_W*i +: ELEM_W];
`ifdef VMEM_STORE_ACK_EN
      if (commit_lanes == LANES) exp_q.push_back({1'b1, {DW{1'b0}}});
`endif
    end else begin
      exp_q.push_back({1'b0, model_load(addr, mask)});
    end
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || busy) begin
      n_checks++;
      $display("FAIL drain: got %0d pending responses, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp_valid(input string name);
    int n = 0;
    @(negedge clk);
    while (!resp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!resp_valid) begin
      n_checks++;
      $display("FAIL %s: got resp_valid=0 for 50 cycles, required 1", name);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_resp: got is_store=%0b data=%h, required no response",
                 resp_is_store, resp_data);
      end else begin
        chk("resp", {resp_is_store, resp_data}, exp_q.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready_en) #1 resp_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0]    wd;
    logic [DW-1:0]    exp_v;
    int               lat;
    rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_addr = '0;
    req_mask = '0; req_wdata = '0; resp_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_req_ready", RW'(req_ready), RW'(1));
    chk("rst_resp_valid", RW'(resp_valid), RW'(0));
    chk("rst_busy", RW'(busy), RW'(0));
    chk("rst_resp_data", RW'(resp_data), RW'(0));
    chk("rst_resp_is_store", RW'(resp_is_store), RW'(0));
    rst = 1'b0;

    // Give every element a known value so the model is fully defined.
    for (int v = 0; v < NVEC; v++) issue(1'b1, v, '1, rand_vec(), LANES);
    wait_idle();

    // Full store then load, with acceptance-to-response latency.
    for (int i = 0; i < LANES; i++) wd[ELEM_W*i +: ELEM_W] = ELEM_W'(32'h100 + i);
    issue(1'b1, 3, 16'hFFFF, wd, LANES);
    issue(1'b0, 3, 16'hFFFF, '0, LANES);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (resp_valid) break;
      @(posedge clk);
      lat++;
    end
    chk("load_latency", RW'(lat), RW'(BEATS));
    wait_idle();

    // Masked store, then masked load.
    for (int i = 0; i < LANES; i++) wd[ELEM_W*i +: ELEM_W] = ELEM_W'(32'hDEAD0000 + i);
    issue(1'b1, 3, 16'h00F0, wd, LANES);
    issue(1'b0, 3, 16'hFFFF, '0, LANES);
    issue(1'b0, 3, 16'h000F, '0, LANES);
    wait_idle();

    // Backpressure: response held for 3 cycles.
    resp_ready = 1'b0;
    exp_v = model_load(3, 16'hFFFF);
    issue(1'b0, 3, 16'hFFFF, '0, LANES);
    wait_resp_valid("bp_wait");
    for (int k = 0; k < 3; k++) begin
      chk("bp_resp_valid", RW'(resp_valid), RW'(1));
      chk("bp_resp_data", RW'(resp_data), RW'(exp_v));
      chk("bp_req_ready", RW'(req_ready), RW'(0));
      if (k < 2) @(negedge clk);
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_req_ready_hs", RW'(req_ready), RW'(0));
    @(negedge clk);
    chk("bp_req_ready_after", RW'(req_ready), RW'(1));
    chk("bp_resp_valid_after", RW'(resp_valid), RW'(0));
    wait_idle();

    // Boundary: last vector store must not disturb vector 0.
    wd = '1;
    issue(1'b1, NVEC - 1, 16'hFFFF, wd, LANES);
    issue(1'b0, 0, 16'hFFFF, '0, LANES);
    issue(1'b0, NVEC - 1, 16'hFFFF, '0, LANES);
    wait_idle();

    // Asynchronous reset mid-cycle while a load response is pending.
    resp_ready = 1'b0;
    issue(1'b0, 7, 16'hFFFF, '0, LANES);
    wait_resp_valid("rst_wait");
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_req_ready", RW'(req_ready), RW'(1));
    chk("async_rst_resp_valid", RW'(resp_valid), RW'(0));
    chk("async_rst_busy", RW'(busy), RW'(0));
    chk("async_rst_resp_data", RW'(resp_data), RW'(0));
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    resp_ready = 1'b1;

    // Abort a store to vector 5 during beat 2: only lanes 0-7 commit, no response.
    issue(1'b1, 5, 16'hFFFF, rand_vec(), 2 * PORT_LANES);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("abort_no_resp", RW'(resp_valid), RW'(0));
    end
    issue(1'b0, 5, 16'hFFFF, '0, LANES);
    wait_idle();

    // Randomized traffic with random response backpressure.
    rand_ready_en = 1'b1;
    for (int n = 0; n < 150; n++)
      issue(1'($urandom_range(0, 1)), $urandom_range(0, NVEC - 1), LANES'($urandom),
            rand_vec(), LANES);
    rand_ready_en = 1'b0;
    @(posedge clk);
    #2 resp_ready = 1'b1;
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vector_mem_ctrl.md
# vector_mem_ctrl

Parametrised vector data memory with a valid/ready request port and a registered response port. Holds `DEPTH` elements of `ELEM_W` bits organised as vectors of `LANES` elements. Moves each vector through an internal array port `PORT_LANES` elements wide over several beats. Supports per-lane masked stores and masked loads, and sits between the vector issue stage and the vector register file.

## Interface
- `ELEM_W`, 32, element width in bits
- `LANES`, 16, elements per vector
- `DEPTH`, 512, total elements; `DEPTH/LANES` must be a power of two
- `PORT_LANES`, 4, elements moved per beat; must divide `LANES`
- derived: `BEATS = LANES/PORT_LANES`, `ADDR_W = clog2(DEPTH/LANES)`

Ports:
- `clk` in 1: clock, rising edge
- `rst` in 1: reset, asynchronous, active-high
- `req_valid` in 1: request present
- `req_ready` out 1: block can accept a request
- `req_is_store` in 1: 1 = store, 0 = load
- `req_addr` in `ADDR_W`: vector index; element base = `req_addr*LANES`
- `req_mask` in `LANES`: lane enable, bit i = lane i
- `req_wdata` in `LANES*ELEM_W`: store data, lane i at `[ELEM_W*i +: ELEM_W]`
- `resp_valid` out 1: response present
- `resp_ready` in 1: consumer takes the response
- `resp_is_store` out 1: response belongs to a store (only with the macro)
- `resp_data` out `LANES*ELEM_W`: load data, same lane packing
- `busy` out 1: state != IDLE

## Operation
- FSM states are IDLE, XFER and RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid&&req_ready`, latch `req_is_store`, `req_addr`, `req_mask` and `req_wdata`.
  - Clear the beat counter and go to XFER.
- XFER:
  - The beat counter `b` runs 0..BEATS-1, one beat per cycle.
  - Beat b covers lanes `b*PORT_LANES .. b*PORT_LANES+PORT_LANES-1`.
  - Store: write each masked-on lane of the beat to element `base+lane`. Masked-off lanes leave memory unchanged.
  - Load: capture each masked-on lane into the `resp_data` register. Masked-off lanes capture 0.
  - After beat BEATS-1, a load goes to RESP.
  - After beat BEATS-1, a store goes to IDLE when the macro is absent, and to RESP when it is present.
- RESP:
  - `resp_valid`=1.
  - `resp_data` and `resp_is_store` are held stable until `resp_valid&&resp_ready`, then the FSM goes to IDLE.
- `req_ready`=0 in XFER and RESP. New requests are never accepted while busy, including in the `resp_ready` handshake cycle.
- The memory array is not reset. Its contents are undefined until written.
- A store writes only elements `base..base+LANES-1`. There is no wrap-around into other vectors.
- Reset asserted mid-XFER aborts the operation:
  - Beats already committed by a store remain in memory.
  - No response is produced.

## Timing
- Reset values:
  - `req_ready`=1, `resp_valid`=0, `resp_is_store`=0, `resp_data`=0, `busy`=0.
  - FSM = IDLE, beat counter = 0.
- The request is accepted at rising edge N.
- Beats complete at edges N+1..N+BEATS.
- Load: `resp_valid`=1 in the cycle after edge N+BEATS, i.e. BEATS cycles after acceptance (4 with the defaults).
- Store without the macro:
  - `req_ready` returns to 1 after edge N+BEATS.
  - A load issued at the earliest opportunity observes all written lanes.
- Store with the macro: `resp_valid` behaves as for a load, with `resp_is_store`=1 and `resp_data`=0.
- The response is taken at edge M when `resp_valid&&resp_ready`. `req_ready`=1 after edge M.
- Minimum load-to-load spacing is BEATS+2 cycles when `resp_ready` is tied high.

## Configuration
- Macro: `VMEM_STORE_ACK_EN`.
- Defined:
  - Stores pass through RESP and produce a response beat.
  - `resp_is_store` reflects the operation type.
- Undefined:
  - Stores return directly to IDLE with no response.
  - `resp_is_store` is tied to 0.
  - `resp_valid` is asserted only for loads.

## Test plan
All scenarios use default parameters.
- Reset: assert `rst` asynchronously mid-cycle -> immediately `req_ready`=1, `resp_valid`=0, `busy`=0, `resp_data`=0.
- Full store then load:
  - Store to addr 3, mask 0xFFFF, lane i = 0x100+i.
  - Then load addr 3, mask 0xFFFF -> `resp_valid` 4 cycles after acceptance, lane i = 0x100+i.
- Masked store:
  - Store to addr 3 with mask 0x00F0, lane i = 0xDEAD0000+i.
  - Load addr 3, mask 0xFFFF -> lanes 4-7 = 0xDEAD0004..0xDEAD0007, other lanes = 0x100+i.
- Masked load: load addr 3 with mask 0x000F -> lanes 0-3 = 0x100..0x103, lanes 4-15 = 0.
- Backpressure:
  - Hold `resp_ready`=0 for 3 cycles on a load response -> `resp_valid` and `resp_data` stable, `req_ready`=0 throughout.
  - `req_ready`=1 the cycle after `resp_ready` is raised.
- Boundary and abort:
  - Store 0xFFFFFFFF (all lanes) to addr 31 -> load addr 0 unchanged.
  - Assert `rst` during beat 2 of a store to addr 5 -> no response; lanes 0-7 of addr 5 updated, lanes 8-15 unchanged.
